// File: rtl/ssd_scan_if.sv
// ssd_scan_if -- bundle between the value producer and the seven-segment
// scan controller.
//   val        : 16-bit display value, digit d = val[4d+3:4d]
//   load       : one-cycle strobe capturing val
//   dp_in      : per-digit decimal-point request, active-high
//   blank_zero : leading-zero blanking enable
//   an         : anode enables, active-low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame      : one-cycle pulse on the last cycle of the digit-3 slot
interface ssd_scan_if;
  logic [15:0] val;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_zero;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  modport master (output val, load, dp_in, blank_zero,
                  input  an, seg, dp, frame);
  modport slave  (input  val, load, dp_in, blank_zero,
                  output an, seg, dp, frame);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- time-multiplexed scan controller for a four-digit
// common-anode seven-segment display.
//   clk, rst_n : single clock domain, asynchronous active-low reset
//   bus        : ssd_scan_if.slave (value/load/dp/blanking in, an/seg/dp/frame out)
// Each digit slot is REFRESH_DIV cycles: BLANK_CYC all-off guard cycles
// followed by DRIVE. The displayed value (disp) changes only at a frame
// boundary, so a frame never mixes old and new digits.

// Per-digit decode lane: glyph for the nibble and the leading-zero chain.
module ssd_digit_lane #(
  parameter bit LSD = 1'b0           // least significant digit, never blanked
) (
  input  logic [3:0] nib,
  input  logic       hi_zero,        // every higher nibble is zero
  input  logic       blank_zero,
  output logic       zero_out,       // this nibble and all higher are zero
  output logic [6:0] seg_o
);
  logic [6:0] glyph;

  always_comb begin
    case (nib)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;   // non-decimal nibbles show a dash
    endcase
  end

  assign zero_out = hi_zero && (nib == 4'd0);
  assign seg_o    = (!LSD && blank_zero && zero_out) ? 7'b1111111 : glyph;
endmodule

module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic     clk,
  input  logic     rst_n,
  ssd_scan_if.slave bus
);
  localparam int NUM_DIG = 4;
  localparam int PW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX     = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLK_LAST = PW'(BLANK_CYC - 1);

  if (REFRESH_DIV < 2 || BLANK_CYC < 1 || BLANK_CYC >= REFRESH_DIV) begin : g_bad_param
    $error("ssd_scan_ctrl: need REFRESH_DIV >= 2 and 1 <= BLANK_CYC < REFRESH_DIV");
  end

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} st_t;

  // pcnt/dig/st describe the slot position whose outputs are registered at
  // the next edge; the output registers therefore trail them by one cycle.
  st_t          st, st_nxt;
  logic [PW-1:0] pcnt;
  logic [1:0]   dig;
  logic [15:0]  disp, hold;
  logic         pend;
  logic         wrap;

  logic [3:0]   an_q, an_d;
  logic [6:0]   seg_q, seg_d;
  logic         dp_q, dp_d;
  logic         frame_q;

  logic [NUM_DIG:0]          zchain;
  logic [NUM_DIG-1:0][6:0]   seg_l;

  assign wrap = (pcnt == PMAX);

  // Leading-zero chain runs from the most significant digit down.
  assign zchain[NUM_DIG] = 1'b1;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_lane
    ssd_digit_lane #(.LSD(g == 0)) u_lane (
      .nib        (disp[4*g +: 4]),
      .hi_zero    (zchain[g+1]),
      .blank_zero (bus.blank_zero),
      .zero_out   (zchain[g]),
      .seg_o      (seg_l[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= BLANK;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    an_d   = 4'b1111;
    seg_d  = 7'b1111111;
    dp_d   = 1'b1;
    case (st)
      BLANK: begin
        if (pcnt == BLK_LAST) st_nxt = DRIVE;
      end
      DRIVE: begin
        if (wrap) st_nxt = BLANK;
        an_d  = ~(4'b0001 << dig);
        seg_d = seg_l[dig];
        dp_d  = ~bus.dp_in[dig];     // honoured even on a blanked digit
      end
      default: st_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      dig     <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      pcnt    <= wrap ? '0 : pcnt + 1'b1;
      if (wrap) dig <= dig + 2'd1;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= wrap && (dig == 2'd3);
    end
  end

  // The frame boundary is the cycle on which frame is visible; a value
  // committed here is in place before digit 0 leaves its guard interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
      hold <= '0;
      pend <= 1'b0;
    end else if (bus.load && frame_q) begin
      disp <= bus.val;
      hold <= bus.val;
      pend <= 1'b0;
    end else begin
      if (bus.load) begin
        hold <= bus.val;
        pend <= 1'b1;
      end
      if (frame_q && pend) begin
        disp <= hold;
        pend <= 1'b0;
      end
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;
endmodule
